// File: rtl/vec_issue_tracker.sv
// -----------------------------------------------------------------------------
// vec_issue_tracker
//
// Scalar-core-side bookkeeping for vector instructions sent to rvv_core.
// Each accepted instruction gets a ring-buffer slot, and the slot index is its
// insn_id. The tracker follows each slot through four steps:
//   issue   : allocated at tail and sent to rvv_core (SPEC)
//   release : declared non-speculative in program order at rel (REL)
//   done    : rvv_core reports completion, illegal flag and result (DONE_*)
//   retire  : freed in program order at head once DONE_REL
// A flush frees every entry that has not yet been released.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        request handshake from the scalar pipeline
//   req_insn_i, req_ctx_i          instruction word and opaque vector context
//   nonspec_i                      release the oldest unreleased instruction
//   flush_i                        kill all unreleased instructions
//   valid_o/ready_i                issue handshake to rvv_core
//   insn_o, insn_id_o,
//   vec_context_o                  issued instruction, id and context
//   flush_o                        flush forwarded to rvv_core
//   insn_can_commit_o/_id_o        commit-release pulse and its id
//   done_i, done_insn_id_i,
//   illegal_insn_i, result_i       completion report from rvv_core
//   retire_valid_o, retire_id_o,
//   retire_illegal_o,
//   retire_result_o                in-order retirement of the head entry
//   count_o                        number of occupied entries
// -----------------------------------------------------------------------------
module vec_issue_tracker #(
    parameter int unsigned NrEntries = 4,
    parameter int unsigned IdWidth   = $clog2(NrEntries),
    parameter int unsigned CtxWidth  = 16,
    parameter int unsigned XLEN      = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_insn_i,
    input  logic [CtxWidth-1:0] req_ctx_i,
    input  logic                nonspec_i,
    input  logic                flush_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [31:0]         insn_o,
    output logic [IdWidth-1:0]  insn_id_o,
    output logic [CtxWidth-1:0] vec_context_o,
    output logic                flush_o,
    output logic                insn_can_commit_o,
    output logic [IdWidth-1:0]  insn_can_commit_id_o,
    input  logic                done_i,
    input  logic [IdWidth-1:0]  done_insn_id_i,
    input  logic                illegal_insn_i,
    input  logic [XLEN-1:0]     result_i,
    output logic                retire_valid_o,
    output logic [IdWidth-1:0]  retire_id_o,
    output logic                retire_illegal_o,
    output logic [XLEN-1:0]     retire_result_o,
    output logic [IdWidth:0]    count_o
);

    typedef enum logic [2:0] {
        S_FREE      = 3'd0,
        S_SPEC      = 3'd1,
        S_REL       = 3'd2,
        S_DONE_SPEC = 3'd3,
        S_DONE_REL  = 3'd4
    } state_e;

    state_e            state_q   [NrEntries];
    state_e            state_d   [NrEntries];
    logic              illegal_q [NrEntries];
    logic [XLEN-1:0]   result_q  [NrEntries];

    logic [IdWidth-1:0] head_q, head_d;
    logic [IdWidth-1:0] rel_q,  rel_d;
    logic [IdWidth-1:0] tail_q, tail_d;
    logic [IdWidth:0]   count_q, count_d;
    logic [IdWidth:0]   flushed;

    logic full;
    logic issue;
    logic release_ok;
    logic retire;
    logic done_wr;

    // Full is judged on the registered count only; a retire in the same
    // cycle does not free a slot for an issue until the next cycle.
    assign full       = (count_q == (IdWidth+1)'(NrEntries));
    assign valid_o    = req_valid_i & ~full & ~flush_i;
    assign req_ready_o = ready_i & ~full & ~flush_i;
    assign issue      = valid_o & ready_i;

    assign insn_o        = req_insn_i;
    assign vec_context_o = req_ctx_i;
    assign insn_id_o     = tail_q;
    assign flush_o       = flush_i;

    // Only an entry already holding SPEC state can be released, so a slot
    // being allocated in this very cycle (still FREE) is never released.
    assign release_ok = nonspec_i &
                        ((state_q[rel_q] == S_SPEC) | (state_q[rel_q] == S_DONE_SPEC));
    assign insn_can_commit_o    = release_ok;
    assign insn_can_commit_id_o = rel_q;

    assign retire           = (state_q[head_q] == S_DONE_REL);
    assign retire_valid_o   = retire;
    assign retire_id_o      = head_q;
    assign retire_illegal_o = illegal_q[head_q];
    assign retire_result_o  = result_q[head_q];
    assign count_o          = count_q;

    // Events are layered in order: issue, release, done, flush, retire.
    // Done is qualified on the registered state so a done for a slot that is
    // FREE (flushed earlier, or only being allocated now) is dropped.
    always_comb begin
        state_d = state_q;
        flushed = '0;
        done_wr = 1'b0;

        if (issue) begin
            state_d[tail_q] = S_SPEC;
        end

        if (release_ok) begin
            state_d[rel_q] = (state_q[rel_q] == S_SPEC) ? S_REL : S_DONE_REL;
        end

        if (done_i && (state_q[done_insn_id_i] != S_FREE)) begin
            done_wr = 1'b1;
            case (state_d[done_insn_id_i])
                S_SPEC:  state_d[done_insn_id_i] = S_DONE_SPEC;
                S_REL:   state_d[done_insn_id_i] = S_DONE_REL;
                default: state_d[done_insn_id_i] = state_d[done_insn_id_i];
            endcase
        end

        if (flush_i) begin
            for (int i = 0; i < NrEntries; i++) begin
                if ((state_d[i] == S_SPEC) || (state_d[i] == S_DONE_SPEC)) begin
                    state_d[i] = S_FREE;
                    flushed    = flushed + 1'b1;
                    if (done_insn_id_i == IdWidth'(i)) begin
                        done_wr = 1'b0;
                    end
                end
            end
        end

        if (retire) begin
            state_d[head_q] = S_FREE;
        end
    end

    always_comb begin
        head_d  = head_q + IdWidth'(retire);
        rel_d   = rel_q + IdWidth'(release_ok);
        tail_d  = flush_i ? rel_d : (tail_q + IdWidth'(issue));
        count_d = count_q + (IdWidth+1)'(issue) - (IdWidth+1)'(retire) - flushed;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            rel_q   <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            rel_q   <= rel_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar gi = 0; gi < NrEntries; gi++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q[gi]   <= S_FREE;
                illegal_q[gi] <= 1'b0;
                result_q[gi]  <= '0;
            end else begin
                state_q[gi] <= state_d[gi];
                if (done_wr && (done_insn_id_i == IdWidth'(gi))) begin
                    illegal_q[gi] <= illegal_insn_i;
                    result_q[gi]  <= result_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_issue_tracker.sv
// -----------------------------------------------------------------------------
// Directed testbench for vec_issue_tracker. Inputs change 1 time unit after
// the rising edge. Combinational outputs are checked 1 unit after that, and
// registered outputs are checked after the following edge.
// -----------------------------------------------------------------------------
module tb_vec_issue_tracker;

    localparam int NrEntries = 4;
    localparam int IdWidth   = 2;
    localparam int CtxWidth  = 16;
    localparam int XLEN      = 64;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [31:0]         req_insn_i;
    logic [CtxWidth-1:0] req_ctx_i;
    logic                nonspec_i;
    logic                flush_i;
    logic                valid_o;
    logic                ready_i;
    logic [31:0]         insn_o;
    logic [IdWidth-1:0]  insn_id_o;
    logic [CtxWidth-1:0] vec_context_o;
    logic                flush_o;
    logic                insn_can_commit_o;
    logic [IdWidth-1:0]  insn_can_commit_id_o;
    logic                done_i;
    logic [IdWidth-1:0]  done_insn_id_i;
    logic                illegal_insn_i;
    logic [XLEN-1:0]     result_i;
    logic                retire_valid_o;
    logic [IdWidth-1:0]  retire_id_o;
    logic                retire_illegal_o;
    logic [XLEN-1:0]     retire_result_o;
    logic [IdWidth:0]    count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    vec_issue_tracker #(
        .NrEntries(NrEntries), .IdWidth(IdWidth), .CtxWidth(CtxWidth), .XLEN(XLEN)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_insn_i(req_insn_i), .req_ctx_i(req_ctx_i),
        .nonspec_i(nonspec_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .insn_o(insn_o), .insn_id_o(insn_id_o), .vec_context_o(vec_context_o),
        .flush_o(flush_o),
        .insn_can_commit_o(insn_can_commit_o), .insn_can_commit_id_o(insn_can_commit_id_o),
        .done_i(done_i), .done_insn_id_i(done_insn_id_i),
        .illegal_insn_i(illegal_insn_i), .result_i(result_i),
        .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o),
        .retire_illegal_o(retire_illegal_o), .retire_result_o(retire_result_o),
        .count_o(count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic idle();
        req_valid_i    = 1'b0;
        req_insn_i     = '0;
        req_ctx_i      = '0;
        nonspec_i      = 1'b0;
        flush_i        = 1'b0;
        ready_i        = 1'b1;
        done_i         = 1'b0;
        done_insn_id_i = '0;
        illegal_insn_i = 1'b0;
        result_i       = '0;
    endtask

    // Advance one clock and land 1 unit after the rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        cyc();
        cyc();
        rst_ni = 1'b1;
    endtask

    // Issue n instructions back to back. The id of each one is checked.
    task automatic issue_n(input int n, input int first_id);
        for (int i = 0; i < n; i++) begin
            req_valid_i = 1'b1;
            req_insn_i  = 32'h1000_0000 + i;
            #1;
            chk($sformatf("issue%0d_id", i), 64'(insn_id_o), 64'((first_id + i) % NrEntries));
            cyc();
        end
        req_valid_i = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle();
        rst_ni = 1'b0;
        #2;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_retire_valid", 64'(retire_valid_o), 64'd0);
        chk("rst_commit", 64'(insn_can_commit_o), 64'd0);
        chk("rst_insn_id", 64'(insn_id_o), 64'd0);
        cyc();
        rst_ni = 1'b1;

        // ---------------- basic flow ----------------
        do_reset();
        req_valid_i = 1'b1;
        req_insn_i  = 32'h00A2_8057;
        req_ctx_i   = 16'h1234;
        #1;
        chk("basic_valid", 64'(valid_o), 64'd1);
        chk("basic_insn", 64'(insn_o), 64'h00A2_8057);
        chk("basic_ctx", 64'(vec_context_o), 64'h1234);
        chk("basic_id", 64'(insn_id_o), 64'd0);
        cyc();
        idle();
        chk("basic_count1", 64'(count_o), 64'd1);
        nonspec_i = 1'b1;
        #1;
        chk("basic_commit", 64'(insn_can_commit_o), 64'd1);
        chk("basic_commit_id", 64'(insn_can_commit_id_o), 64'd0);
        cyc();
        idle();
        done_i = 1'b1; done_insn_id_i = 2'd0; result_i = 64'h5;
        #1;
        chk("basic_no_early_retire", 64'(retire_valid_o), 64'd0);
        cyc();
        idle();
        chk("basic_retire_valid", 64'(retire_valid_o), 64'd1);
        chk("basic_retire_result", retire_result_o, 64'h5);
        chk("basic_retire_id", 64'(retire_id_o), 64'd0);
        cyc();
        chk("basic_count0", 64'(count_o), 64'd0);
        chk("basic_retire_gone", 64'(retire_valid_o), 64'd0);

        // ---------------- fill and wrap ----------------
        do_reset();
        issue_n(4, 0);
        chk("fill_count", 64'(count_o), 64'd4);
        req_valid_i = 1'b1;
        #1;
        chk("fill_ready", 64'(req_ready_o), 64'd0);
        chk("fill_valid", 64'(valid_o), 64'd0);
        idle();
        nonspec_i = 1'b1;
        cyc();
        idle();
        done_i = 1'b1; done_insn_id_i = 2'd0;
        cyc();
        idle();
        chk("fill_retire_valid", 64'(retire_valid_o), 64'd1);
        req_valid_i = 1'b1;
        #1;
        chk("fill_no_bypass_ready", 64'(req_ready_o), 64'd0);
        req_valid_i = 1'b0;
        cyc();
        chk("fill_count3", 64'(count_o), 64'd3);
        req_valid_i = 1'b1;
        #1;
        chk("fill_wrap_ready", 64'(req_ready_o), 64'd1);
        chk("fill_wrap_id", 64'(insn_id_o), 64'd0);
        cyc();
        idle();
        chk("fill_count4", 64'(count_o), 64'd4);

        // ---------------- out-of-order done ----------------
        do_reset();
        issue_n(2, 0);
        nonspec_i = 1'b1;
        #1;
        chk("ooo_rel0", 64'(insn_can_commit_id_o), 64'd0);
        cyc();
        #1;
        chk("ooo_rel1", 64'(insn_can_commit_id_o), 64'd1);
        cyc();
        idle();
        done_i = 1'b1; done_insn_id_i = 2'd1; result_i = 64'h11;
        cyc();
        idle();
        chk("ooo_wait_head", 64'(retire_valid_o), 64'd0);
        done_i = 1'b1; done_insn_id_i = 2'd0; result_i = 64'h10;
        cyc();
        idle();
        chk("ooo_ret0_valid", 64'(retire_valid_o), 64'd1);
        chk("ooo_ret0_id", 64'(retire_id_o), 64'd0);
        chk("ooo_ret0_result", retire_result_o, 64'h10);
        cyc();
        chk("ooo_ret1_valid", 64'(retire_valid_o), 64'd1);
        chk("ooo_ret1_id", 64'(retire_id_o), 64'd1);
        chk("ooo_ret1_result", retire_result_o, 64'h11);
        cyc();
        chk("ooo_count0", 64'(count_o), 64'd0);

        // ---------------- flush ----------------
        do_reset();
        issue_n(3, 0);
        nonspec_i = 1'b1;
        cyc();
        idle();
        flush_i = 1'b1;
        req_valid_i = 1'b1;
        #1;
        chk("flush_o", 64'(flush_o), 64'd1);
        chk("flush_no_valid", 64'(valid_o), 64'd0);
        chk("flush_no_ready", 64'(req_ready_o), 64'd0);
        cyc();
        idle();
        chk("flush_count", 64'(count_o), 64'd1);
        req_valid_i = 1'b1;
        #1;
        chk("flush_next_id", 64'(insn_id_o), 64'd1);
        cyc();
        idle();
        chk("flush_count2", 64'(count_o), 64'd2);
        done_i = 1'b1; done_insn_id_i = 2'd2; result_i = 64'hBAD;
        cyc();
        idle();
        chk("flush_late_done_retire", 64'(retire_valid_o), 64'd0);
        chk("flush_late_done_count", 64'(count_o), 64'd2);

        // ---------------- nonspec + flush same cycle ----------------
        do_reset();
        issue_n(2, 0);
        nonspec_i = 1'b1;
        flush_i   = 1'b1;
        #1;
        chk("nsf_commit", 64'(insn_can_commit_o), 64'd1);
        chk("nsf_commit_id", 64'(insn_can_commit_id_o), 64'd0);
        cyc();
        idle();
        chk("nsf_count", 64'(count_o), 64'd1);
        chk("nsf_next_id", 64'(insn_id_o), 64'd1);

        // ---------------- illegal and async reset ----------------
        do_reset();
        issue_n(1, 0);
        nonspec_i = 1'b1;
        cyc();
        idle();
        done_i = 1'b1; done_insn_id_i = 2'd0; illegal_insn_i = 1'b1; result_i = 64'hDEAD;
        cyc();
        idle();
        chk("ill_retire_valid", 64'(retire_valid_o), 64'd1);
        chk("ill_retire_illegal", 64'(retire_illegal_o), 64'd1);
        cyc();
        issue_n(2, 1);
        chk("midrst_count_before", 64'(count_o), 64'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_count", 64'(count_o), 64'd0);
        chk("midrst_insn_id", 64'(insn_id_o), 64'd0);
        chk("midrst_retire", 64'(retire_valid_o), 64'd0);
        chk("midrst_result", retire_result_o, 64'd0);
        chk("midrst_illegal", 64'(retire_illegal_o), 64'd0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
